// File: rtl/rr_arbiter.sv
// Round-robin grant logic for rr_muxn: a rotating-priority scan, the pointer register,
// and an optional lock that keeps one channel granted across a multi-beat transfer.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int LOCK = 0,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    last,
  input  logic            load,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx
);

  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            locked_q, locked_d;
  logic [IDXW-1:0] lock_idx_q, lock_idx_d;
  logic            accept;
  logic            acc_last;

  // While locked only the owning channel may win, even if it is idle this cycle.
  always_comb begin
    int idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (LOCK != 0 && locked_q) begin
      if (req[lock_idx_q]) begin
        grant[lock_idx_q] = 1'b1;
        grant_idx         = lock_idx_q;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IDXW'(idx);
        end
      end
    end
  end

  assign accept   = load && (|grant);
  assign acc_last = last[grant_idx];

  always_comb begin
    ptr_d      = ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (accept && (LOCK == 0 || acc_last)) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : IDXW'(grant_idx + 1'b1);
    end
    if (LOCK != 0 && accept) begin
      locked_d = !acc_last;
      if (!acc_last) lock_idx_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/rr_muxn.sv
// N-input registered multiplexer with valid/ready on every port; the source channel is
// picked by rr_arbiter. in_ready depends combinationally on out_ready.
module rr_muxn #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int LOCK  = 0,
  parameter int IDXW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDXW-1:0]    out_sel,
  output logic               out_last,
  input  logic               out_ready
);

  logic [N-1:0]     grant;
  logic [IDXW-1:0]  grant_idx;
  logic             load;
  logic             accept;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDXW-1:0]  out_sel_q, out_sel_d;
  logic             out_last_q, out_last_d;

  rr_arbiter #(
    .N    (N),
    .LOCK (LOCK),
    .IDXW (IDXW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .last      (in_last),
    .load      (load),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load     = !out_valid_q || out_ready;
  assign in_ready = load ? grant : '0;
  assign accept   = load && (|grant);

  // Without lock every beat is a complete transfer, so out_last is tied high.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_data_d = in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_sel_d  = grant_idx;
        out_last_d = (LOCK != 0) ? in_last[grant_idx] : 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rr_muxn.sv
// Directed bench for rr_muxn: three instances (N=4, N=3, and N=2 with lock) share clock and reset.
module tb_rr_muxn;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // N=4, LOCK=0
  logic [3:0]   in_valid4 = '0, in_last4 = '0, in_ready4;
  logic [127:0] in_data4 = '0;
  logic         out_valid4, out_last4, out_ready4 = 1'b0;
  logic [31:0]  out_data4;
  logic [1:0]   out_sel4;

  // N=3, LOCK=0
  logic [2:0]  in_valid3 = '0, in_last3 = '0, in_ready3;
  logic [95:0] in_data3 = '0;
  logic        out_valid3, out_last3, out_ready3 = 1'b0;
  logic [31:0] out_data3;
  logic [1:0]  out_sel3;

  // N=2, LOCK=1
  logic [1:0]  in_valid2 = '0, in_last2 = '0, in_ready2;
  logic [63:0] in_data2 = '0;
  logic        out_valid2, out_last2, out_ready2 = 1'b0;
  logic [31:0] out_data2;
  logic [0:0]  out_sel2;

  rr_muxn #(.WIDTH(32), .N(4), .LOCK(0)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_data(in_data4), .in_last(in_last4),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4), .out_sel(out_sel4),
    .out_last(out_last4), .out_ready(out_ready4));

  rr_muxn #(.WIDTH(32), .N(3), .LOCK(0)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_data(in_data3), .in_last(in_last3),
    .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3), .out_sel(out_sel3),
    .out_last(out_last3), .out_ready(out_ready3));

  rr_muxn #(.WIDTH(32), .N(2), .LOCK(1)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2), .out_sel(out_sel2),
    .out_last(out_last2), .out_ready(out_ready2));

  // Producers must keep an unaccepted beat stable.
  logic [3:0]   pend4 = '0;
  logic [2:0]   pend3 = '0;
  logic [1:0]   pend2 = '0;
  logic [127:0] hold4 = '0;
  logic [95:0]  hold3 = '0;
  logic [63:0]  hold2 = '0;
  always @(posedge clk) begin
    if (!reset) begin
      pend4 <= '0;
      pend3 <= '0;
      pend2 <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (pend4[i]) assert (in_valid4[i] && in_data4[i*32 +: 32] == hold4[i*32 +: 32])
          else $error("u4 ch%0d producer dropped an unaccepted beat", i);
      for (int i = 0; i < 3; i++)
        if (pend3[i]) assert (in_valid3[i] && in_data3[i*32 +: 32] == hold3[i*32 +: 32])
          else $error("u3 ch%0d producer dropped an unaccepted beat", i);
      for (int i = 0; i < 2; i++)
        if (pend2[i]) assert (in_valid2[i] && in_data2[i*32 +: 32] == hold2[i*32 +: 32])
          else $error("u2 ch%0d producer dropped an unaccepted beat", i);
      pend4 <= in_valid4 & ~in_ready4;
      pend3 <= in_valid3 & ~in_ready3;
      pend2 <= in_valid2 & ~in_ready2;
      hold4 <= in_data4;
      hold3 <= in_data3;
      hold2 <= in_data2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_valid", 32'(out_valid4), 32'd0);
    check("rst_data", out_data4, 32'd0);
    check("rst_sel", 32'(out_sel4), 32'd0);
    check("rst_last", 32'(out_last4), 32'd0);
    check("rst_last_lock", 32'(out_last2), 32'd0);
    reset = 1'b1;

    // Reset mid-beat
    in_data4[0 +: 32] = 32'hAAAA0001;
    in_valid4 = 4'b0001;
    out_ready4 = 1'b0;
    step();
    check("mid_valid", 32'(out_valid4), 32'd1);
    check("mid_data", out_data4, 32'hAAAA0001);
    check("mid_sel", 32'(out_sel4), 32'd0);
    in_valid4 = 4'b0000;
    #1 reset = 1'b0;
    #1;
    check("async_valid", 32'(out_valid4), 32'd0);
    check("async_data", out_data4, 32'd0);
    check("async_sel", 32'(out_sel4), 32'd0);
    step();
    reset = 1'b1;
    in_data4[64 +: 32] = 32'h22220002;
    in_valid4 = 4'b0100;
    out_ready4 = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready4), 32'h4);
    step();
    check("post_rst_valid", 32'(out_valid4), 32'd1);
    check("post_rst_data", out_data4, 32'h22220002);
    check("post_rst_sel", 32'(out_sel4), 32'd2);
    in_valid4 = 4'b0000;
    step();
    check("post_rst_drain", 32'(out_valid4), 32'd0);

    // Fairness, N=4
    pulse_reset();
    for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'hD0000000 + 32'(i);
    in_valid4 = 4'b1111;
    out_ready4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_valid", 32'(out_valid4), 32'd1);
      check("fair_sel", 32'(out_sel4), 32'(k % 4));
      check("fair_data", out_data4, 32'hD0000000 + 32'(k % 4));
      if (k == 0) check("fair_last", 32'(out_last4), 32'd1);
      if (k >= 4) in_valid4[k % 4] = 1'b0;
    end
    step();
    check("fair_drain", 32'(out_valid4), 32'd0);

    // Wrap with gaps, N=3
    in_data3[0 +: 32]  = 32'h30000000;
    in_data3[64 +: 32] = 32'h30000002;
    in_valid3 = 3'b100;
    out_ready3 = 1'b1;
    #1;
    check("wrap_ready_a", 32'(in_ready3), 32'h4);
    step();
    check("wrap_sel_a", 32'(out_sel3), 32'd2);
    check("wrap_data_a", out_data3, 32'h30000002);
    in_valid3 = 3'b101;
    #1;
    check("wrap_ready_b", 32'(in_ready3), 32'h1);
    step();
    check("wrap_sel_b", 32'(out_sel3), 32'd0);
    check("wrap_data_b", out_data3, 32'h30000000);
    in_valid3 = 3'b100;
    #1;
    check("wrap_ready_c", 32'(in_ready3), 32'h4);
    step();
    check("wrap_sel_c", 32'(out_sel3), 32'd2);
    in_valid3 = 3'b000;
    step();
    check("wrap_drain", 32'(out_valid3), 32'd0);

    // Backpressure, N=4
    in_data4[32 +: 32] = 32'h11110001;
    in_valid4 = 4'b0010;
    out_ready4 = 1'b1;
    step();
    check("bp_first_sel", 32'(out_sel4), 32'd1);
    check("bp_first_data", out_data4, 32'h11110001);
    in_data4[32 +: 32] = 32'h11110002;
    out_ready4 = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_ready", 32'(in_ready4), 32'd0);
      check("bp_data", out_data4, 32'h11110001);
      check("bp_sel", 32'(out_sel4), 32'd1);
      check("bp_valid", 32'(out_valid4), 32'd1);
      step();
    end
    out_ready4 = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready4), 32'h2);
    step();
    check("bp_next_valid", 32'(out_valid4), 32'd1);
    check("bp_next_data", out_data4, 32'h11110002);
    in_valid4 = 4'b0000;
    step();
    check("bp_drain", 32'(out_valid4), 32'd0);

    // Lock, N=2: ch0 three-beat transfer while ch1 waits
    in_data2[0 +: 32]  = 32'hC0000001;
    in_data2[32 +: 32] = 32'hB0000001;
    in_last2 = 2'b10;
    in_valid2 = 2'b11;
    out_ready2 = 1'b1;
    #1;
    check("lock_ready_1", 32'(in_ready2), 32'h1);
    step();
    check("lock_sel_1", 32'(out_sel2), 32'd0);
    check("lock_data_1", out_data2, 32'hC0000001);
    check("lock_last_1", 32'(out_last2), 32'd0);
    in_data2[0 +: 32] = 32'hC0000002;
    #1;
    check("lock_ready_2", 32'(in_ready2), 32'h1);
    step();
    check("lock_data_2", out_data2, 32'hC0000002);
    in_data2[0 +: 32] = 32'hC0000003;
    in_last2 = 2'b11;
    #1;
    check("lock_ready_3", 32'(in_ready2), 32'h1);
    step();
    check("lock_data_3", out_data2, 32'hC0000003);
    check("lock_last_3", 32'(out_last2), 32'd1);
    in_data2[0 +: 32] = 32'hC0000004;
    #1;
    check("lock_ready_ch1", 32'(in_ready2), 32'h2);
    step();
    check("lock_sel_ch1", 32'(out_sel2), 32'd1);
    check("lock_data_ch1", out_data2, 32'hB0000001);
    in_valid2 = 2'b01;
    #1;
    check("lock_ready_wrap", 32'(in_ready2), 32'h1);
    step();
    check("lock_sel_wrap", 32'(out_sel2), 32'd0);
    check("lock_data_wrap", out_data2, 32'hC0000004);
    in_valid2 = 2'b00;
    step();
    check("lock_drain", 32'(out_valid2), 32'd0);

    // Idle drain, N=4
    in_data4[96 +: 32] = 32'h33330003;
    in_valid4 = 4'b1000;
    out_ready4 = 1'b1;
    step();
    check("idle_valid", 32'(out_valid4), 32'd1);
    check("idle_sel", 32'(out_sel4), 32'd3);
    check("idle_data", out_data4, 32'h33330003);
    in_valid4 = 4'b0000;
    step();
    check("idle_valid_off", 32'(out_valid4), 32'd0);
    check("idle_sel_hold", 32'(out_sel4), 32'd3);
    step();
    check("idle_valid_off2", 32'(out_valid4), 32'd0);
    check("idle_sel_hold2", 32'(out_sel4), 32'd3);
    check("idle_data_hold", out_data4, 32'h33330003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
